// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped cache.
package cache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWriteThru
    } cache_state_e;

    function automatic int unsigned calc_off_w(input int unsigned words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int unsigned calc_idx_w(input int unsigned num_blocks);
        return $clog2(num_blocks);
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned num_blocks,
                                               input int unsigned words_per_block);
        return addr_w - calc_idx_w(num_blocks) - calc_off_w(words_per_block);
    endfunction

    function automatic logic [31:0] addr_off(input logic [31:0] addr, input int unsigned off_w);
        return addr & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int unsigned off_w,
                                             input int unsigned idx_w);
        return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned off_w,
                                             input int unsigned idx_w);
        return addr >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Line storage: combinational read port, synchronous write port, no reset.
module cache_data_array #(
    parameter int unsigned IDX_W  = 7,
    parameter int unsigned OFF_W  = 3,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [OFF_W-1:0]  i_woff,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    input  logic [OFF_W-1:0]  i_roff,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << (IDX_W + OFF_W);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[{i_widx, i_woff}] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[{i_ridx, i_roff}];

endmodule

// File: rtl/param_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with block fill on load miss.
module param_dm_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned NUM_BLOCKS      = 128,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_stall,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [CNT_W-1:0]  o_hit_count,
    output logic [CNT_W-1:0]  o_miss_count
);

    localparam int unsigned OFF_W = calc_off_w(WORDS_PER_BLOCK);
    localparam int unsigned IDX_W = calc_idx_w(NUM_BLOCKS);
    localparam int unsigned TAG_W = calc_tag_w(ADDR_W, NUM_BLOCKS, WORDS_PER_BLOCK);

    localparam logic [OFF_W:0]   ISSUE_END = (OFF_W + 1)'(WORDS_PER_BLOCK);
    localparam logic [OFF_W-1:0] LAST_OFF  = OFF_W'(WORDS_PER_BLOCK - 1);

    cache_state_e r_state, w_state_next;

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag [NUM_BLOCKS];
    logic [ADDR_W-1:0]     r_fill_addr;
    logic [OFF_W:0]        r_issue_cnt;
    logic [OFF_W-1:0]      r_recv_cnt;
    logic [CNT_W-1:0]      r_hit_cnt;
    logic [CNT_W-1:0]      r_miss_cnt;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_hit;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_arr_we;
    logic [IDX_W-1:0]  w_arr_idx;
    logic [OFF_W-1:0]  w_arr_off;
    logic [DATA_W-1:0] w_arr_wdata;
    logic              w_hit_inc;
    logic              w_miss_inc;
    logic              w_fill_start;
    logic              w_fill_done;
    logic              w_issue;

    assign w_off      = OFF_W'(addr_off(32'(i_req_addr), OFF_W));
    assign w_idx      = IDX_W'(addr_idx(32'(i_req_addr), OFF_W, IDX_W));
    assign w_tag      = TAG_W'(addr_tag(32'(i_req_addr), OFF_W, IDX_W));
    assign w_fill_idx = IDX_W'(addr_idx(32'(r_fill_addr), OFF_W, IDX_W));
    assign w_fill_tag = TAG_W'(addr_tag(32'(r_fill_addr), OFF_W, IDX_W));
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    cache_data_array #(
        .IDX_W  (IDX_W),
        .OFF_W  (OFF_W),
        .DATA_W (DATA_W)
    ) u_data_array (
        .i_clk   (i_clk),
        .i_we    (w_arr_we),
        .i_widx  (w_arr_idx),
        .i_woff  (w_arr_off),
        .i_wdata (w_arr_wdata),
        .i_ridx  (w_idx),
        .i_roff  (w_off),
        .o_rdata (w_rd_data)
    );

    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        o_rsp_valid  = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = i_req_addr;
        o_mem_wdata  = i_req_wdata;
        w_arr_we     = 1'b0;
        w_arr_idx    = w_idx;
        w_arr_off    = w_off;
        w_arr_wdata  = i_req_wdata;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_fill_start = 1'b0;
        w_fill_done  = 1'b0;
        w_issue      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    if (i_req_write) begin
                        o_stall      = 1'b1;
                        w_state_next = StWriteThru;
                    end else if (w_hit) begin
                        o_rsp_valid = 1'b1;
                        w_hit_inc   = 1'b1;
                    end else begin
                        o_stall      = 1'b1;
                        w_miss_inc   = 1'b1;
                        w_fill_start = 1'b1;
                        w_state_next = StFill;
                    end
                end
            end
            StFill: begin
                o_stall    = 1'b1;
                o_mem_req  = (r_issue_cnt != ISSUE_END);
                o_mem_addr = {r_fill_addr[ADDR_W-1:OFF_W], r_issue_cnt[OFF_W-1:0]};
                w_issue    = o_mem_req && i_mem_ready;
                if (i_mem_rvalid) begin
                    w_arr_we    = 1'b1;
                    w_arr_idx   = w_fill_idx;
                    w_arr_off   = r_recv_cnt;
                    w_arr_wdata = i_mem_rdata;
                    if (r_recv_cnt == LAST_OFF) begin
                        w_fill_done  = 1'b1;
                        w_state_next = StIdle;
                    end
                end
            end
            StWriteThru: begin
                o_mem_req = 1'b1;
                o_mem_we  = 1'b1;
                if (i_mem_ready) begin
                    // Store hits update the line in place; misses never allocate.
                    w_arr_we     = w_hit;
                    w_hit_inc    = w_hit;
                    w_state_next = StIdle;
                end else begin
                    o_stall = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
        o_rsp_rdata = o_rsp_valid ? w_rd_data : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_valid     <= '0;
            r_fill_addr <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fill_start) begin
                r_fill_addr <= i_req_addr;
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end
            if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (r_state == StFill && i_mem_rvalid) begin
                r_recv_cnt <= r_recv_cnt + 1'b1;
            end
            if (w_fill_done) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
            if (w_hit_inc && r_hit_cnt != {CNT_W{1'b1}}) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss_inc && r_miss_cnt != {CNT_W{1'b1}}) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    // Tags are only meaningful under their valid bit, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (w_fill_done) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

    assign o_hit_count  = r_hit_cnt;
    assign o_miss_count = r_miss_cnt;

endmodule

// File: tb/tb_param_dm_cache.sv
// Randomised bench for param_dm_cache against a line-level valid/tag model and a flat memory.
module tb_param_dm_cache;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned NB  = 128;
    localparam int unsigned WPB = 8;
    localparam int unsigned CW  = 16;
    localparam int unsigned CW2 = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          stall, rsp_valid, mem_req, mem_we;
    logic [DW-1:0] rsp_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] hit_count, miss_count;

    logic           d2_stall, d2_rsp_valid, d2_mem_req, d2_mem_we;
    logic [DW-1:0]  d2_rsp_rdata, d2_mem_wdata;
    logic [AW-1:0]  d2_mem_addr;
    logic [CW2-1:0] d2_hit_count, d2_miss_count;

    param_dm_cache #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_BLOCKS(NB), .WORDS_PER_BLOCK(WPB), .CNT_W(CW)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_stall(stall),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_mem_req(mem_req),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_hit_count(hit_count), .o_miss_count(miss_count)
    );

    // Narrow-counter copy sees identical stimulus; only its counters are checked.
    param_dm_cache #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_BLOCKS(NB), .WORDS_PER_BLOCK(WPB), .CNT_W(CW2)
    ) u_dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_write(req_write),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_stall(d2_stall),
        .o_rsp_valid(d2_rsp_valid), .o_rsp_rdata(d2_rsp_rdata), .o_mem_req(d2_mem_req),
        .o_mem_we(d2_mem_we), .o_mem_addr(d2_mem_addr), .o_mem_wdata(d2_mem_wdata),
        .i_mem_ready(mem_ready), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_hit_count(d2_hit_count), .o_miss_count(d2_miss_count)
    );

    typedef struct {
        logic [AW-1:0] addr;
        bit            stale;
    } rd_ent_t;

    logic [DW-1:0] mem_model [0:(1<<AW)-1];
    bit            ref_valid [NB];
    int unsigned   ref_tag [NB];
    int unsigned   ref_hits, ref_misses;

    rd_ent_t       rd_q [$];
    logic [AW-1:0] rd_log [$];
    int            wr_cnt, rv_cnt, ready_delay;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    bit            rand_ready;

    bit            s_stall, s_rsp_valid, s_hs_rd, s_hs_wr, s_rvalid;
    logic [DW-1:0] s_rdata, s_mwdata;
    logic [AW-1:0] s_maddr;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned w);
        int unsigned top = (32'd1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    function automatic int unsigned m_idx(input logic [AW-1:0] a);
        return (int'(a) / WPB) % NB;
    endfunction

    function automatic int unsigned m_tag(input logic [AW-1:0] a);
        return int'(a) / (WPB * NB);
    endfunction

    // Sample outputs at the falling edge, then model memory for the edge just taken.
    task automatic tick();
        rd_ent_t e;
        @(negedge clk);
        s_stall     = stall;
        s_rsp_valid = rsp_valid;
        s_rdata     = rsp_rdata;
        s_hs_rd     = mem_req && mem_ready && !mem_we;
        s_hs_wr     = mem_req && mem_ready && mem_we;
        s_maddr     = mem_addr;
        s_mwdata    = mem_wdata;
        s_rvalid    = mem_rvalid;
        @(posedge clk);
        #1;
        if (s_rvalid) begin
            void'(rd_q.pop_front());
            rv_cnt++;
        end
        if (s_hs_rd) begin
            e.addr  = s_maddr;
            e.stale = 1'b0;
            rd_q.push_back(e);
            rd_log.push_back(s_maddr);
        end
        if (s_hs_wr) begin
            mem_model[s_maddr] = s_mwdata;
            wr_cnt++;
            wr_addr = s_maddr;
            wr_data = s_mwdata;
        end
        if (ready_delay > 0) begin
            mem_ready = 1'b0;
            ready_delay--;
        end else begin
            mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rd_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_q[0].stale ? ~mem_model[rd_q[0].addr] : mem_model[rd_q[0].addr];
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = DW'($urandom);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"}, 32'(hit_count), sat(ref_hits, CW));
        check({tag, "_misses"}, 32'(miss_count), sat(ref_misses, CW));
        check({tag, "_hits_sat"}, 32'(d2_hit_count), sat(ref_hits, CW2));
        check({tag, "_misses_sat"}, 32'(d2_miss_count), sat(ref_misses, CW2));
    endtask

    task automatic do_load(input logic [AW-1:0] addr, input string tag);
        int unsigned   idx, tg;
        bit            exp_hit, done;
        int            stalls, bad_addr, bad_zero;
        logic [AW-1:0] base;
        idx      = m_idx(addr);
        tg       = m_tag(addr);
        exp_hit  = ref_valid[idx] && ref_tag[idx] == tg;
        base     = addr & ~AW'(WPB - 1);
        rd_log.delete();
        wr_cnt   = 0;
        stalls   = 0;
        bad_zero = 0;
        done     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_wdata = DW'($urandom);
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (s_rsp_valid) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (s_rdata != '0) bad_zero++;
            end
        end
        req_valid = 1'b0;
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_data"}, 32'(s_rdata), 32'(mem_model[addr]));
        check({tag, "_stall_ok"}, 32'(s_stall), 0);
        check({tag, "_rdata_zero"}, bad_zero, 0);
        check({tag, "_writes"}, wr_cnt, 0);
        if (exp_hit) begin
            check({tag, "_hit_stalls"}, stalls, 0);
            check({tag, "_hit_reads"}, rd_log.size(), 0);
        end else begin
            bad_addr = 0;
            foreach (rd_log[i]) if (rd_log[i] != base + AW'(i)) bad_addr++;
            check({tag, "_fill_reads"}, rd_log.size(), WPB);
            check({tag, "_fill_addrs"}, bad_addr, 0);
            check({tag, "_fill_stalls"}, 32'(stalls > int'(WPB)), 1);
            ref_misses++;
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        ref_hits++;
        check_counters(tag);
    endtask

    task automatic do_store(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int lag, input int exp_stalls, input string tag);
        int unsigned idx, tg;
        bit          exp_hit, done;
        int          stalls, rsp_seen;
        idx     = m_idx(addr);
        tg      = m_tag(addr);
        exp_hit = ref_valid[idx] && ref_tag[idx] == tg;
        rd_log.delete();
        wr_cnt   = 0;
        stalls   = 0;
        rsp_seen = 0;
        done     = 1'b0;
        if (lag > 0) begin
            ready_delay = lag;
            mem_ready   = 1'b0;
        end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (s_rsp_valid) rsp_seen++;
            if (s_stall) stalls++;
            else done = 1'b1;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_writes"}, wr_cnt, 1);
        check({tag, "_waddr"}, 32'(wr_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(wr_data), 32'(data));
        check({tag, "_reads"}, rd_log.size(), 0);
        check({tag, "_no_rsp"}, rsp_seen, 0);
        if (exp_stalls >= 0) check({tag, "_stalls"}, stalls, exp_stalls);
        if (exp_hit) ref_hits++;
        check_counters(tag);
    endtask

    initial begin
        bit            reached;
        logic [AW-1:0] a;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        mem_ready   = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        rand_ready  = 1'b1;
        ready_delay = 0;
        wr_cnt      = 0;
        rv_cnt      = 0;
        ref_hits    = 0;
        ref_misses  = 0;
        for (int i = 0; i < (1 << AW); i++) mem_model[i] = DW'($urandom);
        for (int i = 0; i < 8; i++) mem_model[16'h1230 + i] = DW'(8'hA0 + i);
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_mem_req", 32'(mem_req), 0);
        check_counters("rst");
        rst_n = 1'b1;

        // Cold miss, fill, replayed hit.
        do_load(16'h1234, "t1");
        check("t1_rdata_a4", 32'(s_rdata), 32'hA4);
        check("t1_miss_one", 32'(miss_count), 1);
        check("t1_hit_one", 32'(hit_count), 1);

        do_load(16'h1237, "t2");
        check("t2_rdata_a7", 32'(s_rdata), 32'hA7);

        // Write-through with slow memory, then store miss without allocation.
        rand_ready = 1'b0;
        do_store(16'h1232, 16'hBEEF, 3, 4, "t3_st_hit");
        do_load(16'h1232, "t3_ld");
        check("t3_beef", 32'(s_rdata), 32'hBEEF);
        do_store(16'h5550, 16'h1357, 0, -1, "t3_st_miss");
        do_load(16'h5550, "t3_ld_miss");
        check("t3_ld_miss_val", 32'(s_rdata), 32'h1357);
        rand_ready = 1'b1;

        // Conflict on one index: 0x0034 and 0x0434 share index 6.
        do_load(16'h0034, "t4_a");
        do_load(16'h0434, "t4_b");
        do_load(16'h0034, "t4_c");

        // Reset mid-fill, drain stale responses while idle, then refill.
        rv_cnt    = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h2345;
        reached   = 1'b0;
        for (int c = 0; c < 300 && !reached; c++) begin
            tick();
            if (rv_cnt == 3) reached = 1'b1;
        end
        check("t5_three_words", 32'(reached), 1);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        foreach (rd_q[i]) rd_q[i].stale = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
        check_counters("t5_rst");
        rd_log.delete();
        for (int c = 0; c < 200 && rd_q.size() > 0; c++) tick();
        check("t5_drained", rd_q.size(), 0);
        check("t5_idle_no_reads", rd_log.size(), 0);
        do_load(16'h2345, "t5_refill");

        // Narrow counters saturate at 15.
        for (int i = 0; i < 20; i++) do_load(16'h2340 + 16'(i % 8), "t6");
        check("t6_sat_15", 32'(d2_hit_count), 15);

        // Random mix over a small address pool to force hits and conflicts.
        for (int i = 0; i < 250; i++) begin
            a = AW'($urandom_range(0, 3) * WPB * NB + $urandom_range(0, 3) * WPB
                    + $urandom_range(0, WPB - 1));
            if ($urandom_range(0, 9) < 3) do_store(a, DW'($urandom), 0, -1, "rnd_st");
            else do_load(a, "rnd_ld");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
